// File: rtl/disp_filter_pkg.sv
// disp_filter_pkg: shared widths and the divider pipeline payload
// for the disparity normalizer.
package disp_filter_pkg;
    localparam int disp_w = 5;
    localparam int conf_w = 8;
    localparam int num_w  = 8 + disp_w;
    localparam int rem_w  = num_w + 1;

    typedef struct packed {
        logic [rem_w-1:0]  rem;
        logic [conf_w-1:0] d;
        logic [disp_w-1:0] q;
        logic [conf_w-1:0] conf;
        logic              sat;
        logic              zero;
        logic              valid;
    } stage_t;
endpackage

// File: rtl/div_stage.sv
// div_stage: one registered restoring-division step resolving quotient bit j.
module div_stage
    import disp_filter_pkg::*;
#(
    parameter int j = 0
) (
    input  logic   clk,
    input  logic   reset_n,
    input  stage_t src,
    output stage_t dst
);
    logic [rem_w-1:0] dj;
    logic             ge;
    stage_t           step;

    assign dj = rem_w'(src.d) << j;
    assign ge = src.rem >= dj;

    always_comb begin
        step      = src;
        step.rem  = ge ? src.rem - dj : src.rem;
        step.q[j] = ge;
    end

    always_ff @(posedge clk) begin
        dst       <= step;
        dst.valid <= reset_n && src.valid;
    end
endmodule

// File: rtl/disp_conf_normalizer.sv
// disp_conf_normalizer: divides smoothed disp*conf by conf per pixel, rounds and
// saturates the result, flags low confidence and frames the stream into lines.
module disp_conf_normalizer
    import disp_filter_pkg::*;
#(
    parameter int disp_bits   = disp_w,
    parameter int line_len    = 120,
    parameter int conf_thresh = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [8+disp_bits-1:0]        disp_conf_in,
    input  logic [7:0]                    conf_in,
    input  logic                          in_valid,
    output logic [disp_bits-1:0]          disp_out,
    output logic [7:0]                    conf_out,
    output logic                          low_conf,
    output logic                          out_valid,
    output logic                          out_sol,
    output logic                          out_eol,
    output logic [$clog2(line_len+1)-1:0] line_low_count
);
    localparam int cnt_w = $clog2(line_len + 1);

    stage_t           s0;
    stage_t           pipe [1:disp_bits];
    stage_t           last;
    logic [rem_w-1:0] n;
    logic [cnt_w-1:0] col;
    logic [cnt_w-1:0] acc;
    logic [cnt_w-1:0] acc_next;
    logic             low;
    logic             eol;

    // Adding conf/2 before the truncating divide gives round-half-up.
    assign n = rem_w'(disp_conf_in) + rem_w'(conf_in >> 1);

    always_ff @(posedge clk) begin
        s0.rem   <= n;
        s0.d     <= conf_in;
        s0.q     <= '0;
        s0.conf  <= conf_in;
        s0.sat   <= n >= (rem_w'(conf_in) << disp_bits);
        s0.zero  <= conf_in == '0;
        s0.valid <= reset_n && in_valid;
    end

    for (genvar k = 1; k <= disp_bits; k++) begin : g_div
        if (k == 1) begin : g_first
            div_stage #(.j(disp_bits - k)) u_stage (
                .clk    (clk),
                .reset_n(reset_n),
                .src    (s0),
                .dst    (pipe[k])
            );
        end else begin : g_next
            div_stage #(.j(disp_bits - k)) u_stage (
                .clk    (clk),
                .reset_n(reset_n),
                .src    (pipe[k-1]),
                .dst    (pipe[k])
            );
        end
    end

    assign last     = pipe[disp_bits];
    assign low      = last.zero || last.conf < conf_w'(conf_thresh);
    assign eol      = col == cnt_w'(line_len - 1);
    assign acc_next = acc + cnt_w'(low);

    always_ff @(posedge clk) begin
        if (!reset_n || !last.valid) begin
            out_valid <= 1'b0;
            disp_out  <= '0;
            conf_out  <= '0;
            low_conf  <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            disp_out  <= last.zero ? '0 : last.sat ? '1 : last.q;
            conf_out  <= last.conf;
            low_conf  <= low;
            out_sol   <= col == '0;
            out_eol   <= eol;
        end
    end

    // The eol pixel's own flag is included before the accumulator clears.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col            <= '0;
            acc            <= '0;
            line_low_count <= '0;
        end else if (last.valid) begin
            col <= eol ? '0 : col + 1'b1;
            acc <= eol ? '0 : acc_next;
            if (eol)
                line_low_count <= acc_next;
        end
    end
endmodule

// File: tb/tb_disp_conf_normalizer.sv
// tb_disp_conf_normalizer: scoreboard bench; a behavioural model predicts each
// output pixel when it is driven and the monitor compares it on arrival.
module tb_disp_conf_normalizer;
    localparam int db = 5;
    localparam int ll = 120;
    localparam int ct = 8;
    localparam int cw = $clog2(ll + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [12:0]   disp_conf_in;
    logic [7:0]    conf_in;
    logic          in_valid;
    logic [db-1:0] disp_out;
    logic [7:0]    conf_out;
    logic          low_conf;
    logic          out_valid;
    logic          out_sol;
    logic          out_eol;
    logic [cw-1:0] line_low_count;

    typedef struct {
        int disp;
        int conf;
        int low;
        int sol;
        int eol;
        int llc;
        int stamp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mcol = 0;
    int   macc = 0;
    int   pushes = 0;
    int   pops = 0;
    bit   mon_en = 1'b0;

    disp_conf_normalizer #(.disp_bits(db), .line_len(ll), .conf_thresh(ct)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .disp_conf_in  (disp_conf_in),
        .conf_in       (conf_in),
        .in_valid      (in_valid),
        .disp_out      (disp_out),
        .conf_out      (conf_out),
        .low_conf      (low_conf),
        .out_valid     (out_valid),
        .out_sol       (out_sol),
        .out_eol       (out_eol),
        .line_low_count(line_low_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int dc, input int cf, output int d, output int low);
        int n;
        n = dc + cf / 2;
        if (cf == 0) d = 0;
        else begin
            d = n / cf;
            if (d > 31) d = 31;
        end
        low = (cf == 0 || cf < ct) ? 1 : 0;
    endfunction

    task automatic tick(input bit v, input int dc, input int cf);
        in_valid     = v;
        disp_conf_in = dc[12:0];
        conf_in      = cf[7:0];
        if (v) begin
            exp_t e;
            model(dc, cf, e.disp, e.low);
            e.conf  = cf;
            e.sol   = (mcol == 0) ? 1 : 0;
            e.eol   = (mcol == ll - 1) ? 1 : 0;
            macc   += e.low;
            e.llc   = macc;
            e.stamp = cyc;
            if (e.eol != 0) begin
                macc = 0;
                mcol = 0;
            end else mcol++;
            sb.push_back(e);
            pushes++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        mcol   = 0;
        macc   = 0;
        pushes = 0;
        pops   = 0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_disp", disp_out, 0);
        chk("rst_conf", conf_out, 0);
        chk("rst_low", low_conf, 0);
        chk("rst_sol", out_sol, 0);
        chk("rst_eol", out_eol, 0);
        chk("rst_llc", line_low_count, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        repeat (12) tick(0, 0, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_count"}, pops, pushes);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) chk("unexpected_valid", out_valid, 0);
                else begin
                    mon_e = sb.pop_front();
                    pops++;
                    chk("disp", disp_out, mon_e.disp);
                    chk("conf", conf_out, mon_e.conf);
                    chk("low", low_conf, mon_e.low);
                    chk("sol", out_sol, mon_e.sol);
                    chk("eol", out_eol, mon_e.eol);
                    chk("latency", cyc, mon_e.stamp + 7);
                    if (mon_e.eol != 0) chk("llc", line_low_count, mon_e.llc);
                end
            end else begin
                chk("idle_disp", disp_out, 0);
                chk("idle_conf", conf_out, 0);
                chk("idle_low", low_conf, 0);
                chk("idle_sol", out_sol, 0);
                chk("idle_eol", out_eol, 0);
            end
        end
    end

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        disp_conf_in = '0;
        conf_in      = '0;
        do_reset();
        // single pixel then rounding, saturation and zero-conf corners
        tick(1, 40, 8);
        repeat (10) tick(0, 0, 0);
        tick(1, 43, 10);
        tick(1, 45, 10);
        tick(1, 4000, 10);
        tick(1, 0, 0);
        drain("corners");
        // one full line with five low-conf pixels, then part of a second
        do_reset();
        for (int i = 0; i < ll + 10; i++) begin
            int cf;
            cf = (i >= 10 && i <= 14) ? 4 : 50;
            tick(1, (i * 37) % (cf * 32), cf);
        end
        drain("line");
        chk("line_low_total", line_low_count, 5);
        // bursty random traffic
        do_reset();
        repeat (300) tick($urandom_range(0, 1) == 1, $urandom_range(0, 8191), $urandom_range(0, 255));
        drain("bursty");
        // reset mid-line, framing restarts
        do_reset();
        for (int i = 0; i < 60; i++) tick(1, i * 50, 20 + i);
        do_reset();
        for (int i = 0; i < ll + 10; i++) tick(1, (i * 91) % 8192, (i * 7) % 256);
        drain("midline");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
